// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle multiply/divide scheduler owning architectural HI/LO.
// The result is computed at start and parked in pend_hi/pend_lo. It retires
// to HI/LO after a fixed busy window, so latency does not depend on operands.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic          pend_we, pend_we_n;   // cleared for divide-by-zero: HI/LO are left untouched
  logic [31:0]   hi_n, lo_n;

  // Arithmetic on the E-stage operands; only sampled when a start is accepted
  logic signed [63:0] rs_sx, rt_sx;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] dvs_s;
  logic [31:0]        dvs_u, q_s, r_s, q_u, r_u;
  logic               div_zero, div_ovf;

  assign rs_sx    = {{32{E_rs[31]}}, E_rs};
  assign rt_sx    = {{32{E_rt[31]}}, E_rt};
  assign prod_s   = rs_sx * rt_sx;
  assign prod_u   = {32'b0, E_rs} * {32'b0, E_rt};
  assign div_zero = (E_rt == 32'd0);
  // Most-negative / -1 overflows a 32-bit quotient; pin it to the wrapped value
  assign div_ovf  = (E_rs == 32'h8000_0000) && (E_rt == 32'hFFFF_FFFF);
  // Substitute a harmless divisor so no simulator sees x/0 or the overflow case
  assign dvs_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(E_rt);
  assign dvs_u    = div_zero ? 32'd1 : E_rt;
  assign q_s      = div_ovf ? 32'h8000_0000 : 32'($signed(E_rs) / dvs_s);
  assign r_s      = div_ovf ? 32'd0 : 32'($signed(E_rs) % dvs_s);
  assign q_u      = E_rs / dvs_u;
  assign r_u      = E_rs % dvs_u;

  assign busy     = (state == RUN);
  assign md_stall = D_md_use & (busy | (E_start & (E_md_op >= OP_MULT) & (E_md_op <= OP_DIVU)));

  // Next-state logic: accept a start in IDLE, count down and retire in RUN
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_we_n = pend_we;
    hi_n      = hi;
    lo_n      = lo;
    case (state)
      IDLE: begin
        if (E_start) begin
          case (E_md_op)
            OP_MULT: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              pend_we_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = RUN;
            end
            OP_MULTU: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              pend_we_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = RUN;
            end
            OP_DIV: begin
              pend_lo_n = q_s;
              pend_hi_n = r_s;
              pend_we_n = ~div_zero;
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = RUN;
            end
            OP_DIVU: begin
              pend_lo_n = q_u;
              pend_hi_n = r_u;
              pend_we_n = ~div_zero;
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = RUN;
            end
            OP_MTHI: hi_n = E_rs;
            OP_MTLO: lo_n = E_rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (pend_we) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_we <= pend_we_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed vectors for the multiply/divide scheduler.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset, E_start, D_md_use;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs, E_rt;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_md_op(E_md_op),
    .E_rs(E_rs), .E_rt(E_rt), .D_md_use(D_md_use),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The bench must never present a start while the unit is running
  always @(posedge clk) if (busy && !reset) chk("no_start_in_run", 64'(E_start), 64'd0);

  // Called at negedge+1ns; issues one op and follows it to completion.
  // Returns at negedge+1ns of the first idle cycle, where the next start may go.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input int n, input logic [31:0] ehi,
                       input logic [31:0] elo);
    int cyc;
    int bad;
    logic [31:0] old_hi, old_lo;
    old_hi = hi; old_lo = lo;
    E_start = 1'b1; E_md_op = op; E_rs = rs; E_rt = rt;
    #1;
    chk({tag, "_busy_start"}, 64'(busy), 64'd0);
    chk({tag, "_stall_start"}, 64'(md_stall), 64'(D_md_use));
    @(negedge clk);
    // Operand changes during the run must not matter
    E_start = 1'b0; E_md_op = 3'd0; E_rs = $urandom; E_rt = $urandom;
    #1;
    cyc = 0; bad = 0;
    while (busy && cyc < 50) begin
      cyc++;
      if (md_stall !== D_md_use) bad++;
      if (hi !== old_hi || lo !== old_lo) bad++;
      @(negedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    chk({tag, "_run_stall_hold"}, 64'(bad), 64'd0);
    chk({tag, "_stall_after"}, 64'(md_stall), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    reset = 1'b1; E_start = 1'b0; E_md_op = 3'd0; E_rs = '0; E_rt = '0; D_md_use = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    @(negedge clk); reset = 1'b0; #1;

    // Multiplies; first with no D-stage consumer so stall must stay low
    D_md_use = 1'b0;
    do_op("mult_m2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    D_md_use = 1'b1;
    do_op("mult_stall", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_7xm5", 3'd1, 32'd7, 32'hFFFF_FFFB, 5, 32'hFFFF_FFFF, 32'hFFFF_FFDD);

    // Divides, including sign cases, overflow and divide-by-zero
    do_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_7_0", 3'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    do_op("div_x_0", 3'd3, 32'd5, 32'd0, 10, 32'd0, 32'h8000_0000);
    do_op("divu_100_7", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    do_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'd16, 10, 32'd15, 32'h0FFF_FFFF);

    // mthi then mtlo back-to-back; neither is multi-cycle
    E_start = 1'b1; E_md_op = 3'd5; E_rs = 32'h1234_5678; #1;
    chk("mthi_stall", 64'(md_stall), 64'd0);
    @(negedge clk);
    E_md_op = 3'd6; E_rs = 32'h9ABC_DEF0; #1;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    E_start = 1'b0; E_md_op = 3'd5; E_rs = 32'hDEAD_BEEF; #1;
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_hi_keep", 64'(hi), 64'h1234_5678);
    chk("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("nostart_hi", 64'(hi), 64'h1234_5678);
    // op 7 with start is ignored
    E_start = 1'b1; E_md_op = 3'd7; #1;
    chk("op7_stall", 64'(md_stall), 64'd0);
    @(negedge clk); E_start = 1'b0; E_md_op = 3'd0; #1;
    chk("op7_busy", 64'(busy), 64'd0);
    chk("op7_hi", 64'(hi), 64'h1234_5678);

    // Reset in the third busy cycle of a divide aborts it
    E_start = 1'b1; E_md_op = 3'd4; E_rs = 32'd100; E_rt = 32'd7;
    @(negedge clk); E_start = 1'b0; E_md_op = 3'd0; #1;
    chk("rstrun_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk); reset = 1'b1; #1;
    chk("rstrun_busy3", 64'(busy), 64'd1);
    @(negedge clk); #1;
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_hi", 64'(hi), 64'd0);
    chk("rstrun_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("rstrun_late_hi", 64'(hi), 64'd0);
    chk("rstrun_late_lo", 64'(lo), 64'd0);
    chk("rstrun_late_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
